// File: rtl/csa_seq_adder.sv
// Multi-cycle wide adder: adds CHUNK_WIDTH bits per cycle, LSB chunk first, carry registered between
// chunks. Define CSA_SEQ_ADDER_OVF_EN to add the signed-overflow output ovf_o.
module csa_seq_adder #(
  parameter int unsigned WORD_WIDTH  = 64,
  parameter int unsigned CHUNK_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  c_i,
  input  logic [WORD_WIDTH-1:0] a_i,
  input  logic [WORD_WIDTH-1:0] b_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [WORD_WIDTH-1:0] r_o,
  output logic                  c_o
`ifdef CSA_SEQ_ADDER_OVF_EN
  ,
  output logic                  ovf_o
`endif
);

  localparam int unsigned N  = WORD_WIDTH / CHUNK_WIDTH;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLast = KW'(N - 1);

  if ((WORD_WIDTH % CHUNK_WIDTH) != 0) begin : gen_width_check
    $error("csa_seq_adder: WORD_WIDTH must be a multiple of CHUNK_WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [WORD_WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic                    carry_q, carry_d;

  // Single chunk adder shared by all chunks
  logic [31:0]             base;
  logic [CHUNK_WIDTH-1:0]  a_chunk, b_chunk, sum_chunk;
  logic                    carry_chunk;
  logic                    last_chunk;

  assign base       = 32'(k_q) * CHUNK_WIDTH;
  assign a_chunk    = a_q[base +: CHUNK_WIDTH];
  assign b_chunk    = b_q[base +: CHUNK_WIDTH];
  assign last_chunk = (k_q == KLast);
  assign {carry_chunk, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk}
                                  + {{CHUNK_WIDTH{1'b0}}, carry_q};

`ifdef CSA_SEQ_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (valid_i)    state_d = StRun;
      StRun:   if (last_chunk) state_d = StDone;
      StDone:  if (ready_i)    state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    ready_o = (state_q == StIdle);
    valid_o = (state_q == StDone);
    r_o     = res_q;
    c_o     = carry_q;
`ifdef CSA_SEQ_ADDER_OVF_EN
    ovf_o   = ovf_q & (state_q == StDone);
`endif
  end

  // Datapath next-state
  always_comb begin
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
`ifdef CSA_SEQ_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == StIdle && valid_i) begin
      a_d     = a_i;
      b_d     = b_i;
      carry_d = c_i;
      res_d   = '0;
      k_d     = '0;
`ifdef CSA_SEQ_ADDER_OVF_EN
      ovf_d   = 1'b0;
`endif
    end else if (state_q == StRun) begin
      res_d[base +: CHUNK_WIDTH] = sum_chunk;
      carry_d = carry_chunk;
      k_d     = last_chunk ? '0 : k_q + KW'(1);
`ifdef CSA_SEQ_ADDER_OVF_EN
      if (last_chunk) begin
        ovf_d = (a_q[WORD_WIDTH-1] == b_q[WORD_WIDTH-1]) &&
                (sum_chunk[CHUNK_WIDTH-1] != a_q[WORD_WIDTH-1]);
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
`ifdef CSA_SEQ_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
`ifdef CSA_SEQ_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule
